// File: rtl/branch_recovery_ctrl.sv
// branch_recovery_ctrl
// Turns an execute-stage branch resolution into a one-cycle PC redirect
// with the matching pipeline flushes. Every branch resolved on the correct
// path also becomes a predictor/BTB training record, queued in a small FIFO
// and offered to the predictor over a valid/ready handshake.
module branch_recovery_ctrl #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int UPD_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // Branch resolution from execute
    input  logic                         br_valid,
    input  logic [1:0]                   br_result,
    input  logic                         br_taken,
    input  logic [WIDTH_DATA_LENGTH-1:0] br_pc,
    input  logic [WIDTH_DATA_LENGTH-1:0] pc_alu,
    input  logic [WIDTH_DATA_LENGTH-1:0] pc_plus4,
    // Recovery toward the fetch PC mux and pipeline registers
    output logic                         redirect_valid,
    output logic [WIDTH_DATA_LENGTH-1:0] redirect_pc,
    output logic                         flush_if_id,
    output logic                         flush_id_ex,
    // Predictor training stream
    output logic                         upd_valid,
    input  logic                         upd_ready,
    output logic [WIDTH_DATA_LENGTH-1:0] upd_pc,
    output logic [WIDTH_DATA_LENGTH-1:0] upd_target,
    output logic                         upd_taken,
    output logic [7:0]                   drop_cnt
);

    localparam int W  = WIDTH_DATA_LENGTH;
    localparam int AW = $clog2(UPD_DEPTH);
    // One extra pointer bit separates "full" from "empty" when the
    // address bits of both pointers coincide.
    localparam int PW = AW + 1;

    // Resolution codes coming from execute
    localparam logic [1:0] RES_WRONG_TGT = 2'b00;
    localparam logic [1:0] RES_CORRECT   = 2'b01;
    localparam logic [1:0] RES_NOT_TAKEN = 2'b10;
    localparam logic [1:0] RES_TAKEN     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_RECOVER  = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] target;
        logic         taken;
    } upd_rec_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    upd_rec_t      fifo_mem_q [UPD_DEPTH];
    upd_rec_t      fifo_mem_d [UPD_DEPTH];

    // ------------------------------------------------------------------
    // Decode of the incoming resolution and FIFO status
    // ------------------------------------------------------------------
    logic          br_accept;     // branch is on the correct path
    logic          br_mispredict; // accepted branch needs a redirect
    logic [W-1:0]  recover_pc;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_pop;
    logic          fifo_push;
    logic          fifo_drop;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    upd_rec_t      new_rec;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_addr == rd_addr);

    // Branches seen while recovering are already on the wrong path, so
    // only a branch resolving in IDLE counts for redirect or training.
    assign br_accept     = br_valid && (state_q == ST_IDLE);
    assign br_mispredict = br_accept && (br_result != RES_CORRECT);

    assign new_rec.pc     = br_pc;
    assign new_rec.target = pc_alu;
    assign new_rec.taken  = br_taken;

    // A full FIFO still takes the record if the head leaves this cycle.
    assign fifo_pop  = !fifo_empty && upd_ready;
    assign fifo_push = br_accept && (!fifo_full || fifo_pop);
    assign fifo_drop = br_accept && fifo_full && !fifo_pop;

    // Select the recovery PC from the resolution code
    always_comb begin
        recover_pc = pc_alu;
        unique case (br_result)
            RES_WRONG_TGT: recover_pc = pc_alu;
            RES_TAKEN:     recover_pc = pc_alu;
            RES_NOT_TAKEN: recover_pc = pc_plus4;
            RES_CORRECT:   recover_pc = pc_alu;
            default:       recover_pc = pc_alu;
        endcase
    end

    // ------------------------------------------------------------------
    // Recovery FSM
    // ------------------------------------------------------------------

    // Next-state logic and redirect PC capture
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (br_mispredict) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = recover_pc;
                end
            end
            // Redirect lasts exactly one cycle.
            ST_REDIRECT: state_d = ST_RECOVER;
            // One more ID/EX squash for the wrong-path instruction that was
            // already in decode while the redirect was issued.
            ST_RECOVER:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM state and captured redirect PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Control outputs are pure decodes of the state register
    always_comb begin
        redirect_valid = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        unique case (state_q)
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
            end
            ST_RECOVER: flush_id_ex = 1'b1;
            default: ;
        endcase
    end

    assign redirect_pc = redirect_pc_q;

    // ------------------------------------------------------------------
    // Update FIFO
    // ------------------------------------------------------------------

    // Pointer advance and saturating drop counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (fifo_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // FIFO pointers and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage entries are reset so the head payload reads zero after reset.
    genvar gi;
    generate
        for (gi = 0; gi < UPD_DEPTH; gi++) begin : g_entry
            // Write-enable decode for this entry
            always_comb begin
                fifo_mem_d[gi] = fifo_mem_q[gi];
                if (fifo_push && (wr_addr == AW'(gi))) fifo_mem_d[gi] = new_rec;
            end

            // Entry register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) fifo_mem_q[gi] <= '0;
                else        fifo_mem_q[gi] <= fifo_mem_d[gi];
            end
        end
    endgenerate

    // Head of the FIFO drives the training payload; it only moves on a pop,
    // so it stays stable while the predictor stalls.
    assign upd_valid  = !fifo_empty;
    assign upd_pc     = fifo_mem_q[rd_addr].pc;
    assign upd_target = fifo_mem_q[rd_addr].target;
    assign upd_taken  = fifo_mem_q[rd_addr].taken;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed testbench for branch_recovery_ctrl (WIDTH 32, UPD_DEPTH 2).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_branch_recovery_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [1:0]  br_result;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] pc_alu;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [7:0]  drop_cnt;

    int tests_run;
    int tests_failed;

    branch_recovery_ctrl #(
        .WIDTH_DATA_LENGTH(32),
        .UPD_DEPTH        (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_valid      (br_valid),
        .br_result     (br_result),
        .br_taken      (br_taken),
        .br_pc         (br_pc),
        .pc_alu        (pc_alu),
        .pc_plus4      (pc_plus4),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic expect_ctrl(input string tag, input logic rv, input logic fif, input logic fie);
        check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check({tag, ".flush_if_id"},    32'(flush_if_id),    32'(fif));
        check({tag, ".flush_id_ex"},    32'(flush_id_ex),    32'(fie));
    endtask

    task automatic expect_upd(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic tk);
        check({tag, ".upd_valid"}, 32'(upd_valid), 32'(v));
        if (v) begin
            check({tag, ".upd_pc"},     upd_pc,          pc);
            check({tag, ".upd_target"}, upd_target,      tgt);
            check({tag, ".upd_taken"},  32'(upd_taken),  32'(tk));
        end
    endtask

    task automatic drive_br(input logic v, input logic [1:0] res, input logic tk,
                            input logic [31:0] pc, input logic [31:0] alu);
        br_valid  = v;
        br_result = res;
        br_taken  = tk;
        br_pc     = pc;
        pc_alu    = alu;
        pc_plus4  = pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the directed sequence is bounded, this only guards a hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        upd_ready    = 1'b0;
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);

        // ---------------- Reset state ----------------
        #2 rst_n = 1'b0;
        tick();
        tick();
        expect_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check("reset.redirect_pc", redirect_pc, 32'h0);
        check("reset.upd_valid",   32'(upd_valid), 32'h0);
        check("reset.upd_pc",      upd_pc, 32'h0);
        check("reset.drop_cnt",    32'(drop_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- Result 11: taken, not predicted ----------------
        upd_ready = 1'b1;
        drive_br(1'b1, 2'b11, 1'b1, 32'h80, 32'h100);
        tick();
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_ctrl("r11.redirect", 1'b1, 1'b1, 1'b1);
        check("r11.redirect_pc", redirect_pc, 32'h100);
        expect_upd("r11.rec", 1'b1, 32'h80, 32'h100, 1'b1);
        tick();
        expect_ctrl("r11.recover", 1'b0, 1'b0, 1'b1);
        check("r11.drained", 32'(upd_valid), 32'h0);
        tick();
        expect_ctrl("r11.idle", 1'b0, 1'b0, 1'b0);

        // ---------------- Result 10 plus ignored wrong-path branches ----------------
        upd_ready = 1'b0;
        drive_br(1'b1, 2'b10, 1'b0, 32'h40, 32'h200);
        tick();
        expect_ctrl("r10.redirect", 1'b1, 1'b1, 1'b1);
        check("r10.redirect_pc", redirect_pc, 32'h44);
        expect_upd("r10.rec", 1'b1, 32'h40, 32'h200, 1'b0);
        // Mispredicts in REDIRECT and RECOVER must be ignored
        drive_br(1'b1, 2'b00, 1'b1, 32'h900, 32'h300);
        tick();
        expect_ctrl("wp.recover", 1'b0, 1'b0, 1'b1);
        drive_br(1'b1, 2'b11, 1'b1, 32'hA00, 32'h400);
        tick();
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_ctrl("wp.idle", 1'b0, 1'b0, 1'b0);
        expect_upd("wp.head", 1'b1, 32'h40, 32'h200, 1'b0);
        upd_ready = 1'b1;
        tick();
        check("wp.no_enqueue", 32'(upd_valid), 32'h0);
        tick();
        expect_ctrl("wp.quiet", 1'b0, 1'b0, 1'b0);

        // ---------------- Result 01: correct prediction ----------------
        upd_ready = 1'b0;
        drive_br(1'b1, 2'b01, 1'b1, 32'h500, 32'h600);
        tick();
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_ctrl("r01", 1'b0, 1'b0, 1'b0);
        expect_upd("r01.rec", 1'b1, 32'h500, 32'h600, 1'b1);
        upd_ready = 1'b1;
        tick();
        check("r01.drained", 32'(upd_valid), 32'h0);

        // ---------------- Stall: three correct branches, one dropped ----------------
        upd_ready = 1'b0;
        drive_br(1'b1, 2'b01, 1'b1, 32'h10, 32'h1010);
        tick();
        drive_br(1'b1, 2'b01, 1'b0, 32'h20, 32'h1020);
        tick();
        expect_upd("stall.head1", 1'b1, 32'h10, 32'h1010, 1'b1);
        drive_br(1'b1, 2'b01, 1'b1, 32'h30, 32'h1030);
        tick();
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_upd("stall.head2", 1'b1, 32'h10, 32'h1010, 1'b1);
        check("stall.drop_cnt", 32'(drop_cnt), 32'd1);
        upd_ready = 1'b1;
        tick();
        expect_upd("drain.rec2", 1'b1, 32'h20, 32'h1020, 1'b0);
        tick();
        check("drain.empty", 32'(upd_valid), 32'h0);

        // ---------------- Full FIFO with simultaneous dequeue ----------------
        upd_ready = 1'b0;
        drive_br(1'b1, 2'b01, 1'b0, 32'h70, 32'h2070);
        tick();
        drive_br(1'b1, 2'b01, 1'b1, 32'h80, 32'h2080);
        tick();
        upd_ready = 1'b1;
        drive_br(1'b1, 2'b01, 1'b0, 32'h90, 32'h2090);
        tick();
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        check("fullpop.drop_cnt", 32'(drop_cnt), 32'd1);
        expect_upd("fullpop.head", 1'b1, 32'h80, 32'h2080, 1'b1);
        tick();
        expect_upd("fullpop.rec3", 1'b1, 32'h90, 32'h2090, 1'b0);
        tick();
        check("fullpop.empty", 32'(upd_valid), 32'h0);

        // ---------------- Drop counter saturation ----------------
        upd_ready = 1'b0;
        drive_br(1'b1, 2'b01, 1'b1, 32'hC0, 32'h30C0);
        for (int i = 0; i < 255; i++) tick();  // 2 fills + 253 drops
        check("sat.drop_cnt_254", 32'(drop_cnt), 32'd254);
        for (int i = 0; i < 47; i++) tick();   // 300 drops in total
        check("sat.drop_cnt_255", 32'(drop_cnt), 32'd255);
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        tick();

        // ---------------- Reset in the middle of REDIRECT ----------------
        // FIFO is full and stalled; the redirect must still happen.
        drive_br(1'b1, 2'b00, 1'b1, 32'hE0, 32'h4000);
        tick();
        drive_br(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        expect_ctrl("rstmid.redirect", 1'b1, 1'b1, 1'b1);
        check("rstmid.redirect_pc", redirect_pc, 32'h4000);
        check("rstmid.drop_cnt", 32'(drop_cnt), 32'd255);
        #1 rst_n = 1'b0;
        #1;
        expect_ctrl("rstmid.async", 1'b0, 1'b0, 1'b0);
        check("rstmid.async.redirect_pc", redirect_pc, 32'h0);
        check("rstmid.async.upd_valid",   32'(upd_valid), 32'h0);
        check("rstmid.async.upd_pc",      upd_pc, 32'h0);
        check("rstmid.async.upd_target",  upd_target, 32'h0);
        check("rstmid.async.upd_taken",   32'(upd_taken), 32'h0);
        check("rstmid.async.drop_cnt",    32'(drop_cnt), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        expect_ctrl("rstmid.after", 1'b0, 1'b0, 1'b0);
        check("rstmid.after.upd_valid", 32'(upd_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
